booth_mult_step: RTL
====================

# booth_mult_step

Iterative radix-2 Booth multiplier sequencer that drives the 65-bit product register of the multdiv unit. On `start` it loads `{32'b0, multiplier, 1'b0}` into the product register. It then performs 32 add/subtract-and-arithmetic-shift steps on the register's current value. Finally it presents the signed 32-bit product and an overflow flag for one cycle. It sits directly upstream of the 65-bit product register: `prod_d` and `prod_we` feed the register's `in` and `write_ctrl` (with `ie` tied high), and the register's `outA` (with `oeA` tied high) returns as `prod_q`.

## Interface
- No parameters. Widths are fixed: 32-bit operands and a 65-bit product register.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `clr_n` in 1: reset, synchronous and active-low.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `data_a` in 32: multiplicand, signed two's complement. Captured on the accepted `start`.
- `data_b` in 32: multiplier, signed. Captured on the accepted `start`, into the register load value.
- `prod_q` in 65: current product register contents.
- `prod_d` out 65: next product register value.
- `prod_we` out 1: product register write enable.
- `busy` out 1: high in RUN and DONE.
- `result_rdy` out 1: one-cycle pulse when `result` and `overflow` are valid.
- `result` out 32: low 32 bits of the signed product. Forced to 0 when `result_rdy` is 0.
- `overflow` out 1: the true 64-bit product does not fit in signed 32 bits. Forced to 0 when `result_rdy` is 0.

## Operation
- States are IDLE, RUN and DONE. Internal registers:
  - `mcand`: 32 bits.
  - 5-bit step counter `cnt`.
  - Flags `a_min` (`data_a == 0x80000000`) and `b_small` (`data_b` is 0 or 1).
- IDLE:
  - With `start=1`: `prod_we=1`, `prod_d={32'b0, data_b, 1'b0}`. Capture `mcand`, `a_min` and `b_small`. Set `cnt=0` and go to RUN.
  - With `start=0`: `prod_we=0`, `prod_d=0`.
- RUN, `prod_we=1`:
  - Set `u=prod_q[64:33]`, then select on `prod_q[1:0]`:
    - 01: `u' = u + mcand`.
    - 10: `u' = u - mcand`.
    - 00 or 11: `u' = u`.
  - Arithmetic is 32-bit with wrap-around; the carry is discarded.
  - `prod_d = {u'[31], u', prod_q[32:1]}`, i.e. `{u', prod_q[32:0]}` arithmetically shifted right by 1.
  - `cnt` increments each RUN cycle. When `cnt==31`, go to DONE.
- DONE, `prod_we=0`:
  - `result_rdy=1`, `result=prod_q[32:1]`.
  - Overflow rule:
    - If `a_min=1`: `overflow = !b_small`.
    - Otherwise: `overflow = (prod_q[64:33] != {32{prod_q[32]}})`.
  - Go to IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued. Operands may change freely after acceptance.
- Reset (`clr_n=0` at an edge), including mid-operation:
  - State becomes IDLE, `cnt=0`, `mcand=0`, both flags 0.
  - The product register is not written during reset. Its stale contents are never reported, because `result_rdy` requires DONE.

## Timing
- Call the cycle where `start` is accepted in IDLE cycle 0.
  - The register is loaded at the end of cycle 0.
  - RUN occupies cycles 1–32, with 32 writes.
  - DONE is cycle 33, with `result_rdy=1`.
  - IDLE resumes in cycle 34, the earliest next accept.
- Throughput is one multiply per 34 cycles. Latency from `start` to `result_rdy` is 33 cycles.
- `prod_d`, `prod_we`, `result` and `overflow` are combinational from state and `prod_q`, or from `start`/`data_b` in IDLE. `busy` and `result_rdy` are decoded from state only.
- Outputs after reset:
  - `prod_we=0`, `busy=0`, `result_rdy=0`, `result=0`, `overflow=0`.
  - `prod_d=0` while `start=0`.
- Reset asserted at any edge yields IDLE outputs in the following cycle. `start` sampled at the same edge as an active reset is ignored.

## Test plan
- 3 × 5:
  - `prod_q` is `0x0_0000_0000_0000_000A` after cycle 0.
  - In cycle 33: `result=15`, `overflow=0`, `result_rdy` high exactly one cycle.
- Signed and cancelling cases:
  - −7 × 6 (`0xFFFFFFF9`, 6) → `result=0xFFFFFFD6`, `overflow=0`.
  - −1 × −1 → `result=1`, `overflow=0`.
- Overflow: `0x00010000 × 0x00010000` → `result=0`, `overflow=1`. `0x7FFFFFFF × 2` → `result=0xFFFFFFFE`, `overflow=1`.
- INT_MIN cases:
  - `0x80000000 × 1` → `0x80000000`, `overflow=0`.
  - `0x80000000 × 0` → `0`, `overflow=0`.
  - `0x80000000 × 0xFFFFFFFF` → `0x80000000`, `overflow=1`.
- Handshake:
  - `start` held high continuously gives accepts in cycles 0 and 34 only.
  - Operands changed in cycle 5 do not alter the result.
  - `busy` is high in cycles 1–33.
- Reset mid-run:
  - `clr_n=0` at cycle 10 → in the next cycle `busy=0`, `prod_we=0`, and no `result_rdy` ever appears for that multiply.
  - A fresh 3 × 5 afterwards returns 15 after 33 cycles.

Source files
------------

// File: rtl/booth_mult_step.sv
// Radix-2 Booth multiplier sequencer driving an external 65-bit product register.
// One multiply takes 34 cycles: load, 32 add/sub-and-shift steps, one result cycle.
`timescale 1ns/1ps
module booth_mult_step (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic [64:0] prod_q,
    output logic [64:0] prod_d,
    output logic        prod_we,
    output logic        busy,
    output logic        result_rdy,
    output logic [31:0] result,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic        a_min;
    logic        b_small;
    logic [31:0] u;
    logic [31:0] u_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            mcand   <= 32'd0;
            a_min   <= 1'b0;
            b_small <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= data_a;
                        a_min   <= (data_a == 32'h8000_0000);
                        b_small <= (data_b == 32'd0) || (data_b == 32'd1);
                        cnt     <= 5'd0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Booth step on the upper half; the carry out of the 32-bit add is dropped.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        u      = prod_q[64:33];
        u_next = u;
        unique case (prod_q[1:0])
            2'b01:   u_next = u + mcand;
            2'b10:   u_next = u - mcand;
            default: u_next = u;
        endcase
    end

    always_comb begin
        prod_d   = '0;
        prod_we  = 1'b0;
        result   = '0;
        overflow = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    prod_d  = {32'd0, data_b, 1'b0};
                    prod_we = clr_n;
                end
            end
            RUN: begin
                prod_d  = {u_next[31], u_next, prod_q[32:1]};
                prod_we = clr_n;
            end
            DONE: begin
                result = prod_q[32:1];
                // INT_MIN multiplicand overflows the 32-bit accumulator, so decide from the operands.
                if (a_min)
                    overflow = !b_small;
                else
                    overflow = (prod_q[64:33] != {32{prod_q[32]}});
            end
            default: ;
        endcase
    end

    assign busy       = (state == RUN) || (state == DONE);
    assign result_rdy = (state == DONE);

endmodule
